// File: rtl/rx_packet_demux_if.sv
// Byte-stream in / per-channel payload out bundle for the packet demux.
// Latency: none (wires only).
// Backpressure: rx_ready toward the UART side, ready_bus from each channel sink.
interface rx_packet_demux_if #(
  parameter int N_CH = 5
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic [N_CH*8-1:0] data_bus;
  logic [N_CH-1:0]   valid_bus;
  logic [N_CH-1:0]   ready_bus;
  logic              pkt_done;
  logic              pkt_err;
  logic [2:0]        my_state;
  logic [7:0]        my_dest;
  logic [7:0]        my_len;
  logic [7:0]        my_cnt;

  // Stream source / channel sinks / observer side.
  modport master (
    output rx_data, rx_valid, ready_bus,
    input  rx_ready, data_bus, valid_bus, pkt_done, pkt_err,
           my_state, my_dest, my_len, my_cnt
  );

  // Demux side.
  modport slave (
    input  rx_data, rx_valid, ready_bus,
    output rx_ready, data_bus, valid_bus, pkt_done, pkt_err,
           my_state, my_dest, my_len, my_cnt
  );
endinterface

// File: rtl/rx_packet_demux.sv
// Parses PREFIX/src/dest/len/payload frames and routes payload bytes to one of N_CH channels.
// Latency: one cycle from accepted rx byte to data_bus/valid_bus; pkt_done/pkt_err are registered pulses.
// Backpressure: rx_ready drops only in DATA while the target channel holds an unconsumed byte.
module rx_packet_demux #(
  parameter int         N_CH    = 5,
  parameter logic [7:0] PREFIX  = 8'hDD,
  parameter int         TIMEOUT = 50000
) (
  input logic            clk,
  input logic            rst,
  rx_packet_demux_if.slave bus
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SRC  = 3'd1,
    S_DEST = 3'd2,
    S_LEN  = 3'd3,
    S_DATA = 3'd4,
    S_DROP = 3'd5
  } state_t;

  state_t            state_q;
  logic [7:0]        my_dest_q;
  logic [7:0]        my_len_q;
  logic [7:0]        my_cnt_q;
  logic [TW-1:0]     timer_q;
  logic              pkt_done_q;
  logic              pkt_err_q;
  logic [N_CH*8-1:0] data_q;
  logic [N_CH-1:0]   valid_q;

  logic rx_ready_d;
  logic sel_vld_d;
  logic sel_rdy_d;
  logic xfer_d;
  logic data_xfer_d;
  logic last_d;
  logic timeout_d;

  // Look up the output slice of the latched destination (only meaningful in DATA).
  always_comb begin
    sel_vld_d = 1'b0;
    sel_rdy_d = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      if (my_dest_q == 8'(k)) begin
        sel_vld_d = valid_q[k];
        sel_rdy_d = bus.ready_bus[k];
      end
    end
  end

  // Accept decode straight from state: only a full target slice can stall the stream.
  always_comb begin
    rx_ready_d  = (state_q == S_DATA) ? (!sel_vld_d || sel_rdy_d) : 1'b1;
    xfer_d      = bus.rx_valid && rx_ready_d;
    data_xfer_d = xfer_d && (state_q == S_DATA);
    // my_len is never 0 in DATA/DROP, so len-1 cannot wrap here.
    last_d      = (my_cnt_q == (my_len_q - 8'd1));
    timeout_d   = (state_q != S_IDLE) && !xfer_d && (timer_q == TW'(TIMEOUT - 1));
  end

  // Frame FSM with inter-byte watchdog and registered completion/error pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      my_dest_q  <= 8'd0;
      my_len_q   <= 8'd0;
      my_cnt_q   <= 8'd0;
      timer_q    <= '0;
      pkt_done_q <= 1'b0;
      pkt_err_q  <= 1'b0;
    end else begin
      pkt_done_q <= 1'b0;
      pkt_err_q  <= 1'b0;

      if (state_q == S_IDLE || xfer_d || timeout_d) begin
        timer_q <= '0;
      end else begin
        timer_q <= timer_q + TW'(1);
      end

      if (timeout_d) begin
        // Abandon the frame; bytes already handed to a slice still drain normally.
        state_q   <= S_IDLE;
        pkt_err_q <= 1'b1;
        my_cnt_q  <= 8'd0;
      end else if (xfer_d) begin
        case (state_q)
          S_IDLE: if (bus.rx_data == PREFIX) state_q <= S_SRC;
          S_SRC:  state_q <= S_DEST;
          S_DEST: begin
            my_dest_q <= bus.rx_data;
            state_q   <= S_LEN;
          end
          S_LEN: begin
            my_len_q <= bus.rx_data;
            my_cnt_q <= 8'd0;
            if (bus.rx_data == 8'd0) begin
              state_q    <= S_IDLE;
              pkt_done_q <= 1'b1;
            end else if (my_dest_q >= 8'(N_CH)) begin
              state_q <= S_DROP;
            end else begin
              state_q <= S_DATA;
            end
          end
          S_DATA: begin
            my_cnt_q <= my_cnt_q + 8'd1;
            if (last_d) begin
              state_q    <= S_IDLE;
              pkt_done_q <= 1'b1;
            end
          end
          S_DROP: begin
            my_cnt_q <= my_cnt_q + 8'd1;
            if (last_d) begin
              state_q   <= S_IDLE;
              pkt_err_q <= 1'b1;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  // Per-channel output registers: load on a payload byte for that channel, drain on its ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= '0;
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        if (data_xfer_d && (my_dest_q == 8'(k))) begin
          data_q[k*8 +: 8] <= bus.rx_data;
          valid_q[k]       <= 1'b1;
        end else if (bus.ready_bus[k]) begin
          valid_q[k] <= 1'b0;
        end
      end
    end
  end

  assign bus.rx_ready  = rx_ready_d;
  assign bus.data_bus  = data_q;
  assign bus.valid_bus = valid_q;
  assign bus.pkt_done  = pkt_done_q;
  assign bus.pkt_err   = pkt_err_q;
  assign bus.my_state  = state_q;
  assign bus.my_dest   = my_dest_q;
  assign bus.my_len    = my_len_q;
  assign bus.my_cnt    = my_cnt_q;

endmodule

// File: tb/tb_rx_packet_demux.sv
// Directed bench for rx_packet_demux: frame routing, filler bytes, bad dest, stalls, empty frames,
// inter-byte timeout and mid-frame reset, checked against hand-written expectations.
// Channel handshakes, pulses and rx transfers are tallied at the falling edge.
module tb_rx_packet_demux;

  localparam int N_CH    = 5;
  localparam int TIMEOUT = 50000;

  logic clk = 1'b0;
  logic rst = 1'b1;

  rx_packet_demux_if #(.N_CH(N_CH)) ifc();

  rx_packet_demux #(.N_CH(N_CH), .PREFIX(8'hDD), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  always #5 clk = ~clk;

  int         vectors     = 0;
  int         miscompares = 0;
  int         done_cnt;
  int         err_cnt;
  int         xfers;
  int         vhi [N_CH];
  logic [7:0] got [N_CH][$];
  logic [7:0] expq [$];
  logic [7:0] txq  [$];

  // Observe the interface mid-cycle: inputs change just after posedge, so values here are what the next edge sees.
  always @(negedge clk) begin
    if (ifc.pkt_done) done_cnt++;
    if (ifc.pkt_err) err_cnt++;
    if (!rst && ifc.rx_valid && ifc.rx_ready) xfers++;
    for (int k = 0; k < N_CH; k++) begin
      if (ifc.valid_bus[k]) begin
        vhi[k]++;
        if (ifc.ready_bus[k]) got[k].push_back(ifc.data_bus[k*8 +: 8]);
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_got(input string tag, input int ch);
    chk({tag, "_count"}, 64'(got[ch].size()), 64'(expq.size()));
    for (int i = 0; i < expq.size(); i++)
      chk($sformatf("%s_byte%0d", tag, i), 64'(got[ch][i]), 64'(expq[i]));
  endtask

  task automatic clear_sb();
    done_cnt = 0;
    err_cnt  = 0;
    xfers    = 0;
    for (int k = 0; k < N_CH; k++) begin
      vhi[k] = 0;
      got[k].delete();
    end
  endtask

  function automatic int vhi_except(input int ch);
    int s = 0;
    for (int k = 0; k < N_CH; k++) if (k != ch) s += vhi[k];
    return s;
  endfunction

  // Present one byte and hold it until accepted; returns just after the accepting edge.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    ifc.rx_data  = b;
    ifc.rx_valid = 1'b1;
    @(negedge clk);
    while (!ifc.rx_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!ifc.rx_ready) chk("send_byte_wait", 64'(ifc.rx_ready), 64'd1);
    @(posedge clk);
    #1;
    ifc.rx_valid = 1'b0;
  endtask

  task automatic send_txq();
    for (int i = 0; i < txq.size(); i++) send_byte(txq[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    int stall_rdy;

    ifc.rx_data   = 8'h00;
    ifc.rx_valid  = 1'b0;
    ifc.ready_bus = '1;
    clear_sb();

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_state",    64'(ifc.my_state),  64'd0);
    chk("rst_valid",    64'(ifc.valid_bus), 64'd0);
    chk("rst_data",     64'(ifc.data_bus),  64'd0);
    chk("rst_done",     64'(ifc.pkt_done),  64'd0);
    chk("rst_err",      64'(ifc.pkt_err),   64'd0);
    chk("rst_cnt",      64'(ifc.my_cnt),    64'd0);
    chk("rst_rx_ready", 64'(ifc.rx_ready),  64'd1);
    @(posedge clk);
    #1 rst = 1'b0;
    clear_sb();

    // 1: plain frame to channel 2
    txq = '{8'hDD, 8'h01, 8'h02, 8'h06, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    send_txq();
    chk("t1_done_pulse", 64'(ifc.pkt_done),       64'd1);
    chk("t1_last_data",  64'(ifc.data_bus[23:16]), 64'h06);
    chk("t1_last_valid", 64'(ifc.valid_bus),      64'h04);
    chk("t1_state",      64'(ifc.my_state),       64'd0);
    idle(4);
    expq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    chk_got("t1_ch2", 2);
    chk("t1_vhi2",   64'(vhi[2]),        64'd6);
    chk("t1_others", 64'(vhi_except(2)), 64'd0);
    chk("t1_done",   64'(done_cnt),      64'd1);
    chk("t1_err",    64'(err_cnt),       64'd0);

    // 2: leading noise bytes are swallowed silently
    clear_sb();
    txq = '{8'h55, 8'hAA, 8'hDD, 8'h01, 8'h02, 8'h06,
            8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    send_txq();
    idle(4);
    chk_got("t2_ch2", 2);
    chk("t2_err",   64'(err_cnt),  64'd0);
    chk("t2_done",  64'(done_cnt), 64'd1);
    chk("t2_xfers", 64'(xfers),    64'd12);

    // 3: destination out of range is dropped
    clear_sb();
    txq = '{8'hDD, 8'h01, 8'h07, 8'h03, 8'h11, 8'h22, 8'h33};
    send_txq();
    chk("t3_err_pulse", 64'(ifc.pkt_err),  64'd1);
    chk("t3_no_done",   64'(ifc.pkt_done), 64'd0);
    idle(4);
    chk("t3_valid_any", 64'(vhi_except(-1)), 64'd0);
    chk("t3_xfers",     64'(xfers),          64'd7);
    chk("t3_err",       64'(err_cnt),        64'd1);
    chk("t3_done",      64'(done_cnt),       64'd0);
    chk("t3_state",     64'(ifc.my_state),   64'd0);
    chk("t3_dest",      64'(ifc.my_dest),    64'h07);
    chk("t3_cnt",       64'(ifc.my_cnt),     64'd3);

    // 4: sink stall on channel 1 holds the stream and the output byte
    clear_sb();
    txq = '{8'hDD, 8'h01, 8'h01, 8'h04, 8'hA1};
    send_txq();
    ifc.ready_bus[1] = 1'b0;
    ifc.rx_data      = 8'hA2;
    ifc.rx_valid     = 1'b1;
    stall_rdy = 0;
    repeat (100) begin
      @(negedge clk);
      if (ifc.rx_ready) stall_rdy++;
    end
    chk("t4_stall_rdy",  64'(stall_rdy),          64'd0);
    chk("t4_held_data",  64'(ifc.data_bus[15:8]), 64'hA1);
    chk("t4_held_valid", 64'(ifc.valid_bus),      64'h02);
    @(posedge clk);
    #1 ifc.ready_bus[1] = 1'b1;
    txq = '{8'hA2, 8'hA3, 8'hA4};
    send_txq();
    idle(4);
    expq = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    chk_got("t4_ch1", 1);
    chk("t4_done", 64'(done_cnt), 64'd1);
    chk("t4_err",  64'(err_cnt),  64'd0);

    // 5: zero-length frame, then a frame straight after it
    clear_sb();
    txq = '{8'hDD, 8'h01, 8'h03, 8'h00};
    send_txq();
    chk("t5_done_pulse", 64'(ifc.pkt_done), 64'd1);
    chk("t5_state",      64'(ifc.my_state), 64'd0);
    txq = '{8'hDD, 8'h01, 8'h00, 8'h02, 8'h5A, 8'h5B};
    send_txq();
    idle(4);
    expq = '{8'h5A, 8'h5B};
    chk_got("t5_ch0", 0);
    chk("t5_vhi3",   64'(vhi[3]),   64'd0);
    chk("t5_done",   64'(done_cnt), 64'd2);
    chk("t5_err",    64'(err_cnt),  64'd0);
    chk("t5_xfers",  64'(xfers),    64'd10);

    // 6: inter-byte timeout inside a payload
    clear_sb();
    txq = '{8'hDD, 8'h01, 8'h02, 8'h04, 8'hAB};
    send_txq();
    n = 0;
    @(negedge clk);
    while (!ifc.pkt_err && n < TIMEOUT + 20) begin
      @(negedge clk);
      n++;
    end
    chk("t6_timeout_cycles", 64'(n),            64'(TIMEOUT));
    chk("t6_state",          64'(ifc.my_state), 64'd0);
    chk("t6_cnt",            64'(ifc.my_cnt),   64'd0);
    idle(4);
    chk("t6_err",  64'(err_cnt),  64'd1);
    chk("t6_done", 64'(done_cnt), 64'd0);
    expq = '{8'hAB};
    chk_got("t6_ch2", 2);
    clear_sb();
    txq = '{8'hDD, 8'h01, 8'h02, 8'h01, 8'h77};
    send_txq();
    idle(4);
    expq = '{8'h77};
    chk_got("t6_next_ch2", 2);
    chk("t6_next_done", 64'(done_cnt), 64'd1);

    // 6b: reset in the middle of a payload
    clear_sb();
    ifc.ready_bus[3] = 1'b0;
    txq = '{8'hDD, 8'h01, 8'h03, 8'h05, 8'hC1};
    send_txq();
    chk("t6r_pre_cnt",   64'(ifc.my_cnt),    64'd1);
    chk("t6r_pre_len",   64'(ifc.my_len),    64'd5);
    chk("t6r_pre_valid", 64'(ifc.valid_bus), 64'h08);
    rst = 1'b1;
    @(negedge clk);
    chk("t6r_state",    64'(ifc.my_state),  64'd0);
    chk("t6r_valid",    64'(ifc.valid_bus), 64'd0);
    chk("t6r_data",     64'(ifc.data_bus),  64'd0);
    chk("t6r_dest",     64'(ifc.my_dest),   64'd0);
    chk("t6r_len",      64'(ifc.my_len),    64'd0);
    chk("t6r_cnt",      64'(ifc.my_cnt),    64'd0);
    chk("t6r_pulses",   64'({ifc.pkt_done, ifc.pkt_err}), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    ifc.ready_bus = '1;
    idle(3);
    chk("t6r_done_after", 64'(done_cnt), 64'd0);
    chk("t6r_err_after",  64'(err_cnt),  64'd0);
    clear_sb();
    txq = '{8'hDD, 8'h01, 8'h04, 8'h02, 8'hE1, 8'hE2};
    send_txq();
    idle(4);
    expq = '{8'hE1, 8'hE2};
    chk_got("t6r_ch4", 4);
    chk("t6r_next_done", 64'(done_cnt), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
